axis_insert_pkt_arbiter: RTL and testbench

//  Shares one axi_stream_insert_header datapath between NUM_SRC requesters. Each requester

---
 rtl/axis_insert_pkt_arbiter_if.sv | 59 +++++
 rtl/axis_insert_pkt_arbiter.sv | 161 ++++++++++++++++
 tb/tb_axis_insert_pkt_arbiter.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_insert_pkt_arbiter_if.sv
// Bus bundle for axis_insert_pkt_arbiter: the per-source header/payload
// channels (packed, source i at slice i) and the single header/payload
// channel that feeds the downstream insert block.
//   master : arbiter view (drives m_* and s_ready_*)
//   slave  : environment view (sources and insert block)
interface axis_insert_pkt_arbiter_if #(
  parameter int DATA_WD = 32,
  parameter int NUM_SRC = 4
);
  localparam int DATA_BYTE_WD = DATA_WD / 8;
  localparam int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD);

  // source-side header channels
  logic [NUM_SRC-1:0]              s_valid_insert;
  logic [NUM_SRC*DATA_WD-1:0]      s_data_insert;
  logic [NUM_SRC*DATA_BYTE_WD-1:0] s_keep_insert;
  logic [NUM_SRC*BYTE_CNT_WD-1:0]  s_byte_insert_cnt;
  logic [NUM_SRC-1:0]              s_ready_insert;
  // source-side payload channels
  logic [NUM_SRC-1:0]              s_valid_in;
  logic [NUM_SRC*DATA_WD-1:0]      s_data_in;
  logic [NUM_SRC*DATA_BYTE_WD-1:0] s_keep_in;
  logic [NUM_SRC-1:0]              s_last_in;
  logic [NUM_SRC-1:0]              s_ready_in;
  // insert-block header channel
  logic                            m_valid_insert;
  logic [DATA_WD-1:0]              m_data_insert;
  logic [DATA_BYTE_WD-1:0]         m_keep_insert;
  logic [BYTE_CNT_WD-1:0]          m_byte_insert_cnt;
  logic                            m_ready_insert;
  // insert-block payload channel
  logic                            m_valid_in;
  logic [DATA_WD-1:0]              m_data_in;
  logic [DATA_BYTE_WD-1:0]         m_keep_in;
  logic                            m_last_in;
  logic                            m_ready_in;

  modport master (
    input  s_valid_insert, s_data_insert, s_keep_insert, s_byte_insert_cnt,
    output s_ready_insert,
    input  s_valid_in, s_data_in, s_keep_in, s_last_in,
    output s_ready_in,
    output m_valid_insert, m_data_insert, m_keep_insert, m_byte_insert_cnt,
    input  m_ready_insert,
    output m_valid_in, m_data_in, m_keep_in, m_last_in,
    input  m_ready_in
  );

  modport slave (
    output s_valid_insert, s_data_insert, s_keep_insert, s_byte_insert_cnt,
    input  s_ready_insert,
    output s_valid_in, s_data_in, s_keep_in, s_last_in,
    input  s_ready_in,
    input  m_valid_insert, m_data_insert, m_keep_insert, m_byte_insert_cnt,
    output m_ready_insert,
    input  m_valid_in, m_data_in, m_keep_in, m_last_in,
    output m_ready_in
  );
endinterface

// File: rtl/axis_insert_pkt_arbiter.sv
// axis_insert_pkt_arbiter
// Packet-level arbiter in front of an axi_stream_insert_header block.
// One source is granted per packet: its header goes out first, then its
// payload, and the grant is held until the last payload beat is accepted.
// The datapath is a pure mux on the registered grant, so no data latency
// is added. Default selection is round-robin starting after the last
// granted source; defining AXIS_ARB_FIXED_PRIO_EN switches to fixed
// priority (lowest requesting index wins).
module axis_insert_pkt_arbiter #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
  parameter int NUM_SRC      = 4,
  parameter int SRC_WD       = $clog2(NUM_SRC)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  axis_insert_pkt_arbiter_if.master        bus,
  output logic [SRC_WD-1:0]                grant_id,
  output logic                             busy,
  output logic [15:0]                      pkt_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_BODY = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_s;
  logic [SRC_WD-1:0]   grant_id_r;
  logic [SRC_WD-1:0]   last_grant_r;
  logic [15:0]         pkt_cnt_r;
  logic [SRC_WD:0]     pick_s;       // {found, index}
  logic                hdr_fire_s;
  logic                last_fire_s;

  // Selection: returns {found, index} of the winning requester.
  function automatic logic [SRC_WD:0] select_src(input logic [NUM_SRC-1:0] req,
                                                 input logic [SRC_WD-1:0]  last);
    logic [SRC_WD:0] res;
    int              cand;
    res = {(SRC_WD+1){1'b0}};
`ifdef AXIS_ARB_FIXED_PRIO_EN
    // walk downward so the lowest requesting index is written last
    cand = 0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (req[k]) begin
        res = {1'b1, SRC_WD'(k)};
      end
    end
    if (last == {SRC_WD{1'b0}}) begin
      cand = 0;
    end
`else
    // walk from the farthest candidate to the nearest one after 'last'
    for (int k = NUM_SRC; k >= 1; k--) begin
      cand = (int'(last) + k) % NUM_SRC;
      if (req[cand]) begin
        res = {1'b1, SRC_WD'(cand)};
      end
    end
`endif
    return res;
  endfunction

  assign pick_s      = select_src(bus.s_valid_insert, last_grant_r);
  assign hdr_fire_s  = (state_r == ST_HDR) && bus.s_valid_insert[grant_id_r] && bus.m_ready_insert;
  assign last_fire_s = (state_r == ST_BODY) && bus.s_valid_in[grant_id_r] &&
                       bus.m_ready_in && bus.s_last_in[grant_id_r];

  assign grant_id = grant_id_r;
  assign busy     = (state_r != ST_IDLE);
  assign pkt_cnt  = pkt_cnt_r;

  // State, grant and packet-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      grant_id_r   <= {SRC_WD{1'b0}};
      last_grant_r <= SRC_WD'(NUM_SRC - 1);
      pkt_cnt_r    <= 16'd0;
    end else begin
      state_r <= state_s;
      if ((state_r == ST_IDLE) && pick_s[SRC_WD]) begin
        grant_id_r <= pick_s[SRC_WD-1:0];
      end
      if (last_fire_s) begin
        last_grant_r <= grant_id_r;
        pkt_cnt_r    <= pkt_cnt_r + 16'd1;
      end
    end
  end

  // Next-state: IDLE -> HDR on any request, HDR -> BODY on header
  // handshake, BODY -> IDLE on last payload handshake.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (pick_s[SRC_WD]) begin
          state_s = ST_HDR;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_HDR: begin
        if (hdr_fire_s) begin
          state_s = ST_BODY;
        end else begin
          state_s = ST_HDR;
        end
      end
      ST_BODY: begin
        if (last_fire_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_BODY;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Output muxes: only the granted source is connected, and only to the
  // channel that the current phase allows.
  always_comb begin
    bus.m_valid_insert    = 1'b0;
    bus.m_data_insert     = {DATA_WD{1'b0}};
    bus.m_keep_insert     = {DATA_BYTE_WD{1'b0}};
    bus.m_byte_insert_cnt = {BYTE_CNT_WD{1'b0}};
    bus.s_ready_insert    = {NUM_SRC{1'b0}};
    bus.m_valid_in        = 1'b0;
    bus.m_data_in         = {DATA_WD{1'b0}};
    bus.m_keep_in         = {DATA_BYTE_WD{1'b0}};
    bus.m_last_in         = 1'b0;
    bus.s_ready_in        = {NUM_SRC{1'b0}};
    case (state_r)
      ST_HDR: begin
        bus.m_valid_insert    = bus.s_valid_insert[grant_id_r];
        bus.m_data_insert     = bus.s_data_insert[grant_id_r*DATA_WD +: DATA_WD];
        bus.m_keep_insert     = bus.s_keep_insert[grant_id_r*DATA_BYTE_WD +: DATA_BYTE_WD];
        bus.m_byte_insert_cnt = bus.s_byte_insert_cnt[grant_id_r*BYTE_CNT_WD +: BYTE_CNT_WD];
        bus.s_ready_insert[grant_id_r] = bus.m_ready_insert;
      end
      ST_BODY: begin
        bus.m_valid_in = bus.s_valid_in[grant_id_r];
        bus.m_data_in  = bus.s_data_in[grant_id_r*DATA_WD +: DATA_WD];
        bus.m_keep_in  = bus.s_keep_in[grant_id_r*DATA_BYTE_WD +: DATA_BYTE_WD];
        bus.m_last_in  = bus.s_last_in[grant_id_r];
        bus.s_ready_in[grant_id_r] = bus.m_ready_in;
      end
      default: begin
        bus.m_valid_insert = 1'b0;
        bus.m_valid_in     = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_axis_insert_pkt_arbiter.sv
// Directed testbench for axis_insert_pkt_arbiter (4 sources, 32-bit data).
// Inputs change 1 ns after the rising edge; outputs are checked 1 ns later.
module tb_axis_insert_pkt_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  grant_id;
  logic        busy;
  logic [15:0] pkt_cnt;
  int          chk_cnt = 0;
  int          pass_cnt = 0;

  axis_insert_pkt_arbiter_if #(.DATA_WD(32), .NUM_SRC(4)) bus ();

  axis_insert_pkt_arbiter #(.DATA_WD(32), .NUM_SRC(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .grant_id (grant_id),
    .busy     (busy),
    .pkt_cnt  (pkt_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] hdr_word(input int src);
    return 32'hA5A5_0000 | 32'(src);
  endfunction

  function automatic logic [31:0] pay_word(input int src, input int beat);
    return 32'hD000_0000 | (32'(src) << 8) | 32'(beat);
  endfunction

  function automatic logic [3:0] onehot(input int src);
    logic [3:0] v;
    v = 4'b0001;
    return v << src;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_hdr(input int src, input logic v);
    bus.s_valid_insert[src]              = v;
    bus.s_data_insert[src*32 +: 32]      = hdr_word(src);
    bus.s_keep_insert[src*4 +: 4]        = 4'hF;
    bus.s_byte_insert_cnt[src*2 +: 2]    = 2'(src);
  endtask

  task automatic set_pay(input int src, input logic v, input logic [31:0] d, input logic l);
    bus.s_valid_in[src]          = v;
    bus.s_data_in[src*32 +: 32]  = d;
    bus.s_keep_in[src*4 +: 4]    = 4'hF;
    bus.s_last_in[src]           = l;
  endtask

  task automatic clear_inputs();
    bus.s_valid_insert    = 4'h0;
    bus.s_data_insert     = 128'h0;
    bus.s_keep_insert     = 16'h0;
    bus.s_byte_insert_cnt = 8'h0;
    bus.s_valid_in        = 4'h0;
    bus.s_data_in         = 128'h0;
    bus.s_keep_in         = 16'h0;
    bus.s_last_in         = 4'h0;
    bus.m_ready_insert    = 1'b1;
    bus.m_ready_in        = 1'b1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus.s_valid_insert = 4'hF;
    bus.s_valid_in     = 4'hF;
    tick();
    chk_cnt++; if (bus.m_valid_insert !== 1'b0) $display("FAIL rst_m_valid_insert got=%0b exp=0", bus.m_valid_insert); else pass_cnt++;
    chk_cnt++; if (bus.m_valid_in !== 1'b0) $display("FAIL rst_m_valid_in got=%0b exp=0", bus.m_valid_in); else pass_cnt++;
    chk_cnt++; if (bus.s_ready_insert !== 4'h0) $display("FAIL rst_s_ready_insert got=%h exp=0", bus.s_ready_insert); else pass_cnt++;
    chk_cnt++; if (bus.s_ready_in !== 4'h0) $display("FAIL rst_s_ready_in got=%h exp=0", bus.s_ready_in); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy got=%0b exp=0", busy); else pass_cnt++;
    chk_cnt++; if (pkt_cnt !== 16'd0) $display("FAIL rst_pkt_cnt got=%0d exp=0", pkt_cnt); else pass_cnt++;
    chk_cnt++; if (grant_id !== 2'd0) $display("FAIL rst_grant_id got=%0d exp=0", grant_id); else pass_cnt++;
    clear_inputs();
    rst_n = 1'b1;
  endtask

  // src2 alone: header then a 3-beat packet
  task automatic test_single_src();
    apply_reset();
    set_hdr(2, 1'b1);
    set_pay(2, 1'b1, pay_word(2, 0), 1'b0);
    #1;
    chk_cnt++; if (busy !== 1'b0 || bus.m_valid_insert !== 1'b0) $display("FAIL t1_arb_latency busy=%0b mvi=%0b exp=0,0", busy, bus.m_valid_insert); else pass_cnt++;
    tick();
    chk_cnt++; if (grant_id !== 2'd2) $display("FAIL t1_grant got=%0d exp=2", grant_id); else pass_cnt++;
    chk_cnt++; if (bus.m_valid_insert !== 1'b1 || bus.m_data_insert !== hdr_word(2)) $display("FAIL t1_hdr got v=%0b d=%h exp v=1 d=%h", bus.m_valid_insert, bus.m_data_insert, hdr_word(2)); else pass_cnt++;
    chk_cnt++; if (bus.m_byte_insert_cnt !== 2'd2 || bus.m_keep_insert !== 4'hF) $display("FAIL t1_hdr_cnt_keep got cnt=%0d keep=%h exp 2,f", bus.m_byte_insert_cnt, bus.m_keep_insert); else pass_cnt++;
    chk_cnt++; if (bus.s_ready_insert !== 4'b0100) $display("FAIL t1_s_ready_insert got=%b exp=0100", bus.s_ready_insert); else pass_cnt++;
    chk_cnt++; if (bus.m_valid_in !== 1'b0 || bus.s_ready_in !== 4'h0) $display("FAIL t1_no_payload_in_hdr got mv=%0b sr=%b exp 0,0000", bus.m_valid_in, bus.s_ready_in); else pass_cnt++;
    tick();
    set_hdr(2, 1'b0);
    for (int b = 0; b < 3; b++) begin
      set_pay(2, 1'b1, pay_word(2, b), (b == 2));
      #1;
      chk_cnt++; if (bus.m_valid_in !== 1'b1 || bus.m_data_in !== pay_word(2, b)) $display("FAIL t1_beat%0d got v=%0b d=%h exp v=1 d=%h", b, bus.m_valid_in, bus.m_data_in, pay_word(2, b)); else pass_cnt++;
      chk_cnt++; if (bus.m_last_in !== (b == 2)) $display("FAIL t1_last%0d got=%0b exp=%0b", b, bus.m_last_in, (b == 2)); else pass_cnt++;
      chk_cnt++; if (bus.s_ready_in !== 4'b0100 || bus.m_valid_insert !== 1'b0) $display("FAIL t1_body_ready%0d got sr=%b mvi=%0b exp 0100,0", b, bus.s_ready_in, bus.m_valid_insert); else pass_cnt++;
      tick();
    end
    set_pay(2, 1'b0, 32'h0, 1'b0);
    #1;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL t1_busy_after got=%0b exp=0", busy); else pass_cnt++;
    chk_cnt++; if (pkt_cnt !== 16'd1) $display("FAIL t1_pkt_cnt got=%0d exp=1", pkt_cnt); else pass_cnt++;
  endtask

  // all four requesting continuously with 1-beat packets
  task automatic test_round_robin();
    apply_reset();
    for (int s = 0; s < 4; s++) begin
      set_hdr(s, 1'b1);
      set_pay(s, 1'b1, pay_word(s, 0), 1'b1);
    end
    for (int p = 0; p < 5; p++) begin
      int e;
      e = p % 4;
      tick();
      chk_cnt++; if (grant_id !== 2'(e) || bus.m_data_insert !== hdr_word(e)) $display("FAIL t2_grant_p%0d got g=%0d d=%h exp g=%0d", p, grant_id, bus.m_data_insert, e); else pass_cnt++;
      chk_cnt++; if (bus.s_ready_insert !== onehot(e)) $display("FAIL t2_s_ready_insert_p%0d got=%b exp=%b", p, bus.s_ready_insert, onehot(e)); else pass_cnt++;
      tick();
      chk_cnt++; if (bus.m_data_in !== pay_word(e, 0) || bus.s_ready_in !== onehot(e)) $display("FAIL t2_body_p%0d got d=%h sr=%b exp d=%h sr=%b", p, bus.m_data_in, bus.s_ready_in, pay_word(e, 0), onehot(e)); else pass_cnt++;
      tick();
      chk_cnt++; if (busy !== 1'b0) $display("FAIL t2_gap_p%0d busy got=%0b exp=0", p, busy); else pass_cnt++;
    end
    chk_cnt++; if (pkt_cnt !== 16'd5) $display("FAIL t2_pkt_cnt got=%0d exp=5", pkt_cnt); else pass_cnt++;
  endtask

  // insert block stalls the header for 5 cycles
  task automatic test_hdr_stall();
    apply_reset();
    bus.m_ready_insert = 1'b0;
    set_hdr(1, 1'b1);
    set_pay(1, 1'b1, pay_word(1, 0), 1'b1);
    tick();
    for (int i = 0; i < 5; i++) begin
      #1;
      chk_cnt++; if (bus.m_valid_insert !== 1'b1 || bus.s_ready_insert !== 4'h0) $display("FAIL t3_stall%0d got mvi=%0b sri=%b exp 1,0000", i, bus.m_valid_insert, bus.s_ready_insert); else pass_cnt++;
      chk_cnt++; if (bus.m_valid_in !== 1'b0 || bus.s_ready_in !== 4'h0) $display("FAIL t3_no_payload%0d got mv=%0b sr=%b exp 0,0000", i, bus.m_valid_in, bus.s_ready_in); else pass_cnt++;
      tick();
    end
    bus.m_ready_insert = 1'b1;
    #1;
    chk_cnt++; if (bus.s_ready_insert !== 4'b0010) $display("FAIL t3_release got=%b exp=0010", bus.s_ready_insert); else pass_cnt++;
    tick();
    set_hdr(1, 1'b0);
    #1;
    chk_cnt++; if (bus.m_valid_in !== 1'b1 || bus.m_data_in !== pay_word(1, 0) || bus.s_ready_in !== 4'b0010) $display("FAIL t3_body got v=%0b d=%h sr=%b exp 1,%h,0010", bus.m_valid_in, bus.m_data_in, bus.s_ready_in, pay_word(1, 0)); else pass_cnt++;
    tick();
    chk_cnt++; if (pkt_cnt !== 16'd1 || busy !== 1'b0) $display("FAIL t3_done got cnt=%0d busy=%0b exp 1,0", pkt_cnt, busy); else pass_cnt++;
  endtask

  // toggling m_ready_in during a 4-beat src0 packet while src1 waits
  task automatic test_body_backpressure();
    int  beat;
    bit  done;
    apply_reset();
    set_hdr(0, 1'b1);
    set_hdr(1, 1'b1);
    set_pay(0, 1'b1, pay_word(0, 0), 1'b0);
    set_pay(1, 1'b1, pay_word(1, 0), 1'b1);
    tick();
    chk_cnt++; if (grant_id !== 2'd0) $display("FAIL t4_grant0 got=%0d exp=0", grant_id); else pass_cnt++;
    tick();
    set_hdr(0, 1'b0);
    beat = 0;
    done = 1'b0;
    for (int cyc = 0; cyc < 20 && !done; cyc++) begin
      bus.m_ready_in = (cyc % 2 == 1);
      set_pay(0, 1'b1, pay_word(0, beat), (beat == 3));
      #1;
      chk_cnt++; if (bus.s_ready_in !== {3'b000, bus.m_ready_in}) $display("FAIL t4_ready_c%0d got=%b exp=000%0b", cyc, bus.s_ready_in, bus.m_ready_in); else pass_cnt++;
      chk_cnt++; if (bus.m_data_in !== pay_word(0, beat) || bus.m_last_in !== (beat == 3)) $display("FAIL t4_data_c%0d got d=%h l=%0b exp d=%h", cyc, bus.m_data_in, bus.m_last_in, pay_word(0, beat)); else pass_cnt++;
      if (bus.m_ready_in) begin
        if (beat == 3) done = 1'b1;
        beat++;
      end
      tick();
    end
    chk_cnt++; if (!done) $display("FAIL t4_timeout beats=%0d exp=4", beat); else pass_cnt++;
    set_pay(0, 1'b0, 32'h0, 1'b0);
    bus.m_ready_in = 1'b1;
    #1;
    chk_cnt++; if (busy !== 1'b0 || pkt_cnt !== 16'd1) $display("FAIL t4_done got busy=%0b cnt=%0d exp 0,1", busy, pkt_cnt); else pass_cnt++;
    tick();
    chk_cnt++; if (grant_id !== 2'd1 || bus.s_ready_insert !== 4'b0010) $display("FAIL t4_grant1 got g=%0d sri=%b exp 1,0010", grant_id, bus.s_ready_insert); else pass_cnt++;
  endtask

  // asynchronous reset in the middle of a src1 payload
  task automatic test_reset_mid_body();
    apply_reset();
    set_hdr(2, 1'b1);
    set_pay(2, 1'b1, pay_word(2, 0), 1'b1);
    tick();
    tick();
    tick();
    set_hdr(2, 1'b0);
    set_pay(2, 1'b0, 32'h0, 1'b0);
    set_hdr(1, 1'b1);
    set_pay(1, 1'b1, pay_word(1, 0), 1'b0);
    #1;
    chk_cnt++; if (pkt_cnt !== 16'd1) $display("FAIL t5_pre_cnt got=%0d exp=1", pkt_cnt); else pass_cnt++;
    tick();
    tick();
    set_hdr(1, 1'b0);
    #1;
    chk_cnt++; if (bus.m_valid_in !== 1'b1 || grant_id !== 2'd1) $display("FAIL t5_in_body got mv=%0b g=%0d exp 1,1", bus.m_valid_in, grant_id); else pass_cnt++;
    #2;
    rst_n = 1'b0;
    #1;
    chk_cnt++; if (bus.m_valid_in !== 1'b0 || bus.s_ready_in !== 4'h0) $display("FAIL t5_async_payload got mv=%0b sr=%b exp 0,0000", bus.m_valid_in, bus.s_ready_in); else pass_cnt++;
    chk_cnt++; if (bus.m_valid_insert !== 1'b0 || bus.s_ready_insert !== 4'h0 || busy !== 1'b0) $display("FAIL t5_async_hdr got mvi=%0b sri=%b busy=%0b exp 0", bus.m_valid_insert, bus.s_ready_insert, busy); else pass_cnt++;
    chk_cnt++; if (pkt_cnt !== 16'd0) $display("FAIL t5_cnt got=%0d exp=0", pkt_cnt); else pass_cnt++;
    clear_inputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    set_hdr(0, 1'b1);
    set_hdr(3, 1'b1);
    set_pay(0, 1'b1, pay_word(0, 0), 1'b1);
    set_pay(3, 1'b1, pay_word(3, 0), 1'b1);
    tick();
    chk_cnt++; if (grant_id !== 2'd0) $display("FAIL t5_first_after_rst got=%0d exp=0", grant_id); else pass_cnt++;
  endtask

  // src0 and src3 requesting continuously
  task automatic test_prio();
    logic [1:0] exp_g [3];
`ifdef AXIS_ARB_FIXED_PRIO_EN
    exp_g[0] = 2'd0; exp_g[1] = 2'd0; exp_g[2] = 2'd0;
`else
    exp_g[0] = 2'd0; exp_g[1] = 2'd3; exp_g[2] = 2'd0;
`endif
    apply_reset();
    set_hdr(0, 1'b1);
    set_hdr(3, 1'b1);
    set_pay(0, 1'b1, pay_word(0, 0), 1'b1);
    set_pay(3, 1'b1, pay_word(3, 0), 1'b1);
    for (int p = 0; p < 3; p++) begin
      tick();
      chk_cnt++; if (grant_id !== exp_g[p]) $display("FAIL t6_grant_p%0d got=%0d exp=%0d", p, grant_id, exp_g[p]); else pass_cnt++;
      tick();
      tick();
    end
    #1;
    chk_cnt++; if (pkt_cnt !== 16'd3) $display("FAIL t6_pkt_cnt got=%0d exp=3", pkt_cnt); else pass_cnt++;
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_src();
    test_round_robin();
    test_hdr_stall();
    test_body_backpressure();
    test_reset_mid_body();
    test_prio();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d passed=%0d", chk_cnt, pass_cnt);
    $fatal(1, "watchdog");
  end

endmodule
